// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide sequencer owning HI/LO with decode-stage stall request
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDop,
  input  logic [31:0] SRCA,
  input  logic [31:0] SRCB,
  input  logic        D_is_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic [31:0] p_hi, p_lo, sq, sr, uq, ur, quo, rem;
  logic [63:0] prod;
  logic acc, is_md, is_mul, is_sdiv, ovf, done;
  assign sq = $signed(SRCA) / $signed(SRCB);
  assign sr = $signed(SRCA) % $signed(SRCB);
  assign uq = SRCA / SRCB;
  assign ur = SRCA % SRCB;
  always_comb begin
    is_md = MDop >= 3'd1 && MDop <= 3'd4;
    is_mul = MDop == 3'd1 || MDop == 3'd2;
    is_sdiv = MDop == 3'd3;
    acc = start && state == IDLE;
    done = state == RUN && cnt == 4'd1;
    busy = state == RUN;
    stall = D_is_md && (busy || (start && is_md));
    state_n = acc && is_md ? RUN : done ? IDLE : state;
    prod = MDop == 3'd1 ? {{32{SRCA[31]}}, SRCA} * {{32{SRCB[31]}}, SRCB}
                        : {32'b0, SRCA} * {32'b0, SRCB};
    ovf = is_sdiv && SRCA == 32'h8000_0000 && SRCB == 32'hffff_ffff;
    quo = ovf ? SRCA : is_sdiv ? sq : uq;
    rem = ovf ? 32'd0 : is_sdiv ? sr : ur;
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 4'd0;
      HI <= 32'd0;
      LO <= 32'd0;
      p_hi <= 32'd0;
      p_lo <= 32'd0;
    end else begin
      if (acc && is_md) begin
        cnt <= is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
        {p_hi, p_lo} <= is_mul ? prod : SRCB == 32'd0 ? {HI, LO} : {rem, quo};
      end else if (done) begin
        cnt <= 4'd0;
        HI <= p_hi;
        LO <= p_lo;
      end else if (busy) cnt <= cnt - 4'd1;
      if (acc && MDop == 3'd5) HI <= SRCA;
      if (acc && MDop == 3'd6) LO <= SRCA;
    end
  end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: scoreboard bench for mdu_ctrl with directed vectors
module tb_mdu_ctrl;
  logic clk = 0, reset, start, D_is_md, busy, stall;
  logic [2:0] MDop;
  logic [31:0] SRCA, SRCB, HI, LO;
  typedef struct {logic [31:0] hi; logic [31:0] lo; int cyc;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  logic rst_q = 1'b1;
  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .MDop(MDop), .SRCA(SRCA), .SRCB(SRCB),
    .D_is_md(D_is_md), .busy(busy), .stall(stall), .HI(HI), .LO(LO)
  );
  always #5 clk = ~clk;
  always @(posedge clk) rst_q <= reset;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  initial begin
    logic prev = 1'b0;
    int run = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy) run++;
      if (prev && !busy) begin
        if (!rst_q) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_completion: HI %h LO %h with empty queue", HI, LO);
          end else begin
            e = q.pop_front();
            chk("result_hi", HI, e.hi);
            chk("result_lo", LO, e.lo);
            chk("busy_cycles", run, e.cyc);
          end
        end
        run = 0;
      end
      prev = busy;
    end
  end
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1; MDop = op; SRCA = a; SRCB = b;
    @(posedge clk); #1;
    start = 0; MDop = 0;
  endtask
  task automatic expect_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] hi, input logic [31:0] lo, input int cyc);
    q.push_back('{hi, lo, cyc});
    issue(op, a, b);
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    chk("idle_timeout", busy, 0);
  endtask
  initial begin
    reset = 1; start = 1; MDop = 1; SRCA = 32'd5; SRCB = 32'd7; D_is_md = 0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_hi", HI, 0);
      chk("rst_lo", LO, 0);
    end
    @(posedge clk); #1;
    reset = 0; start = 0; MDop = 0;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_hi", HI, 0);
    chk("post_rst_lo", LO, 0);
    expect_op(3'd1, 32'hffff_fffe, 32'd3, 32'hffff_ffff, 32'hffff_fffa, 5);
    expect_op(3'd2, 32'hffff_fffe, 32'd3, 32'h0000_0002, 32'hffff_fffa, 5);
    expect_op(3'd3, 32'hffff_fff9, 32'd2, 32'hffff_ffff, 32'hffff_fffd, 10);
    expect_op(3'd4, 32'd7, 32'd2, 32'd1, 32'd3, 10);
    expect_op(3'd3, 32'h8000_0000, 32'hffff_ffff, 32'd0, 32'h8000_0000, 10);
    expect_op(3'd3, 32'd7, 32'hffff_fffe, 32'd1, 32'hffff_fffd, 10);
    @(posedge clk); #1;
    start = 1; MDop = 5; SRCA = 32'h1234;
    @(posedge clk); #1;
    MDop = 6; SRCA = 32'h5678;
    @(negedge clk);
    chk("mthi_hi", HI, 32'h1234);
    chk("mthi_busy", busy, 0);
    @(posedge clk); #1;
    start = 0; MDop = 0;
    @(negedge clk);
    chk("mtlo_lo", LO, 32'h5678);
    chk("mtlo_hi", HI, 32'h1234);
    chk("mtlo_busy", busy, 0);
    issue(3'd5, 32'h11, 32'd0);
    issue(3'd6, 32'h22, 32'd0);
    expect_op(3'd3, 32'h99, 32'd0, 32'h11, 32'h22, 10);
    issue(3'd7, 32'hdead, 32'd0);
    @(negedge clk);
    chk("op7_busy", busy, 0);
    chk("op7_hi", HI, 32'h11);
    chk("op7_lo", LO, 32'h22);
    q.push_back('{32'd0, 32'h2a, 5});
    @(posedge clk); #1;
    start = 1; MDop = 1; SRCA = 32'd6; SRCB = 32'd7; D_is_md = 1;
    @(negedge clk);
    chk("stall_start", stall, 1);
    @(posedge clk); #1;
    for (int i = 1; i <= 5; i++) begin
      if (i == 3) begin
        start = 1; MDop = 6; SRCA = 32'haaaa;
      end else begin
        start = 0; MDop = 0;
      end
      @(negedge clk);
      chk("stall_busy", stall, 1);
      chk("lo_held", LO, 32'h22);
      @(posedge clk); #1;
    end
    start = 0; MDop = 0;
    @(negedge clk);
    chk("stall_done", stall, 0);
    chk("overlap_lo", LO, 32'h2a);
    D_is_md = 0;
    issue(3'd3, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_hi", HI, 0);
    chk("abort_lo", LO, 0);
    repeat (15) @(negedge clk);
    chk("abort_hi_late", HI, 0);
    chk("abort_lo_late", LO, 0);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multiply/divide unit and sequencer for the 5-stage MIPS pipeline; sits in EX beside the ALU and shares its SRCA/SRCB operands. Accepts mult/multu/div/divu/mthi/mtlo commands from EX, models fixed multi-cycle latency with a busy counter, and owns the architectural HI/LO registers. Produces the stall request that holds a decode-stage HI/LO-touching instruction while an operation is starting or in flight.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal 1..15)
DIV_CYCLES, 10, busy cycles for div/divu (legal 1..15)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high; clears all state
start  input  1  EX-stage command valid; one-cycle pulse per instruction
MDop  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
SRCA  input  32  rs operand (dividend / multiplicand / mthi-mtlo data)
SRCB  input  32  rt operand (divisor / multiplier)
D_is_md  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
busy  output  1  operation in progress
stall  output  1  = D_is_md & (busy | (start & MDop in 1..4)); combinational
HI  output  32  architectural HI
LO  output  32  architectural LO

Behaviour:
- Reset (synchronous, priority over everything): busy=0, counter=0, HI=0, LO=0, pending regs=0. Reset mid-operation aborts it; no HI/LO update.
- Accept: command taken on an edge where start=1 and busy=0. start while busy=1 is ignored (pipeline guarantees no such case via stall; the block must not corrupt state).
- mult/multu/div/divu accepted at edge E0: pending_hi/pending_lo computed from SRCA/SRCB at E0 and registered; counter<=N (MULT_CYCLES or DIV_CYCLES); busy=1 from E0.
- Each subsequent edge with counter>1: counter decrements. Edge with counter==1: counter<=0, busy<=0, HI<=pending_hi, LO<=pending_lo. busy is high for exactly N cycles; new HI/LO visible on the same cycle busy falls.
- HI/LO hold old values throughout busy (mfhi/mflo must be stalled by the pipeline; stall covers it).
- mthi/mtlo accepted: HI (or LO) <= SRCA at that edge; busy stays 0; zero latency.
- Arithmetic: mult = $signed 32x32 -> 64, multu unsigned; {HI,LO} = product. div/divu: LO = quotient, HI = remainder; signed quotient truncates toward zero, remainder takes dividend sign. 0x80000000 div 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: full DIV_CYCLES busy, HI and LO unchanged at completion.
- MDop 0 or 7 with start=1: no effect.
- State: IDLE (busy=0) -> RUN on accepted mult/div; RUN -> IDLE on counter==1 edge; RUN -> IDLE on reset. No other states.
- stall is purely combinational; no registered latency.

Test Plan:
- Reset: assert reset 2 cycles with start=1, MDop=1 -> HI=0, LO=0, busy=0 throughout and after release.
- Signed mult: SRCA=0xFFFFFFFE (-2), SRCB=3, MDop=1 at E0 -> busy=1 for 5 cycles, HI=0xFFFFFFFF, LO=0xFFFFFFFA on 6th cycle; multu same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- Signed div: SRCA=0xFFFFFFF9 (-7), SRCB=2, MDop=3 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/2 -> LO=3, HI=1; div by zero with HI=0x11, LO=0x22 preset -> unchanged after 10 cycles.
- Overlap/stall: start mult, then D_is_md=1 for cycles 1..5 -> stall=1 each cycle; start pulse during busy with MDop=6, SRCA=0xAAAA -> LO unaffected by it, mult result lands normally.
- mthi/mtlo: MDop=5 SRCA=0x1234 then MDop=6 SRCA=0x5678 on consecutive cycles -> HI=0x1234, LO=0x5678 next edge each, busy stays 0.
- Reset mid-op: div started, reset at busy cycle 4 -> busy=0, HI=LO=0 next cycle; no later update appears.
